// File: rtl/alu_iter_exec.sv
// Iterative ALU execute stage: decodes ALUOp/funct fields and executes single-cycle ops,
// plus a shift-add multiplier. Define ALU_ITER_DIV_EN to add a restoring unsigned divider.
module alu_iter_exec #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [1:0]      alu_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SH_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  // Handshake: a transfer happens on a rising edge where valid && ready; out_valid holds
  // its result stable until out_ready is seen, and in_ready is high only in IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL    = 2'd1,
`ifdef ALU_ITER_DIV_EN
    DIV_ST = 2'd3,
`endif
    OUT    = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
    OP_OR, OP_AND, OP_MUL, OP_DIVU, OP_REMU, OP_ILL
  } op_t;

  state_t            state, state_n;
  op_t               op;
  logic [6:0]        funct7;
  logic [2:0]        funct3;
  logic [SH_W-1:0]   shamt;
  logic [XLEN-1:0]   alu_res;
  logic              accept;
  logic [XLEN-1:0]   mcand, mplier, acc;
  logic [XLEN-1:0]   mul_sum;
  logic [CNT_W-1:0]  cnt;
  logic              unused_insn;

  assign funct7      = instruction[31:25];
  assign funct3      = instruction[14:12];
  assign unused_insn = ^{instruction[24:15], instruction[11:0]};
  assign shamt       = op_b[SH_W-1:0];
  assign in_ready    = rst_n && (state == IDLE);
  assign out_valid   = (state == OUT);
  assign accept      = in_valid && in_ready;

  always_comb begin
    op = OP_ILL;
    case (alu_op)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b10: begin
        case ({funct7, funct3})
          10'b0000000_000: op = OP_ADD;
          10'b0100000_000: op = OP_SUB;
          10'b0000000_001: op = OP_SLL;
          10'b0000000_010: op = OP_SLT;
          10'b0000000_011: op = OP_SLTU;
          10'b0000000_100: op = OP_XOR;
          10'b0000000_101: op = OP_SRL;
          10'b0100000_101: op = OP_SRA;
          10'b0000000_110: op = OP_OR;
          10'b0000000_111: op = OP_AND;
          10'b0000001_000: op = OP_MUL;
`ifdef ALU_ITER_DIV_EN
          10'b0000001_101: op = OP_DIVU;
          10'b0000001_111: op = OP_REMU;
`endif
          default:         op = OP_ILL;
        endcase
      end
      default: begin
        // Immediate forms: funct7 only matters for the shift encodings
        case (funct3)
          3'b000:  op = OP_ADD;
          3'b001:  op = (funct7 == 7'b0000000) ? OP_SLL : OP_ILL;
          3'b010:  op = OP_SLT;
          3'b011:  op = OP_SLTU;
          3'b100:  op = OP_XOR;
          3'b101:  op = (funct7 == 7'b0100000) ? OP_SRA : OP_SRL;
          3'b110:  op = OP_OR;
          default: op = OP_AND;
        endcase
      end
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_SLL:  alu_res = op_a << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      OP_OR:   alu_res = op_a | op_b;
      OP_AND:  alu_res = op_a & op_b;
      default: alu_res = '0;
    endcase
  end

  assign mul_sum = acc + (mplier[0] ? mcand : '0);

`ifdef ALU_ITER_DIV_EN
  // Divider reuses the multiplier registers: acc = partial remainder,
  // mplier = dividend shifting into quotient, mcand = divisor.
  logic [XLEN:0]   div_trial;
  logic            div_ge;
  logic [XLEN-1:0] rem_next, quot_next;
  logic            rem_sel;

  assign div_trial = {acc, mplier[XLEN-1]};
  assign div_ge    = (div_trial >= {1'b0, mcand});
  assign rem_next  = div_ge ? XLEN'(div_trial - {1'b0, mcand}) : div_trial[XLEN-1:0];
  assign quot_next = {mplier[XLEN-2:0], div_ge};
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (op == OP_MUL) state_n = MUL;
`ifdef ALU_ITER_DIV_EN
          else if (op == OP_DIVU || op == OP_REMU) state_n = DIV_ST;
`endif
          else state_n = OUT;
        end
      end
      MUL:     if (cnt == LAST_ITER) state_n = OUT;
`ifdef ALU_ITER_DIV_EN
      DIV_ST:  if (cnt == LAST_ITER) state_n = OUT;
`endif
      OUT:     if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
`ifdef ALU_ITER_DIV_EN
      rem_sel <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc <= '0;
            cnt <= '0;
            if (op == OP_MUL) begin
              mcand  <= op_a;
              mplier <= op_b;
            end
`ifdef ALU_ITER_DIV_EN
            else if (op == OP_DIVU || op == OP_REMU) begin
              mcand   <= op_b;
              mplier  <= op_a;
              rem_sel <= (op == OP_REMU);
            end
`endif
            else begin
              // Illegal ops fall through alu_res's zero default
              result  <= alu_res;
              zero    <= (alu_res == '0);
              illegal <= (op == OP_ILL);
            end
          end
        end
        MUL: begin
          acc    <= mul_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            result  <= mul_sum;
            zero    <= (mul_sum == '0);
            illegal <= 1'b0;
          end
        end
`ifdef ALU_ITER_DIV_EN
        DIV_ST: begin
          acc    <= rem_next;
          mplier <= quot_next;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            result  <= rem_sel ? rem_next : quot_next;
            zero    <= ((rem_sel ? rem_next : quot_next) == '0);
            illegal <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter_exec.sv
// Self-checking bench for alu_iter_exec: directed and random ops checked against an
// arithmetic reference model; honours ALU_ITER_DIV_EN the same way as the design.
module tb_alu_iter_exec;

  localparam int XLEN = 32;

  localparam int K_ADD = 0, K_SUB = 1, K_SLL = 2, K_SLT = 3, K_SLTU = 4, K_XOR = 5,
                 K_SRL = 6, K_SRA = 7, K_OR = 8, K_AND = 9, K_MUL = 10, K_DIVU = 11,
                 K_REMU = 12, K_ILL = 13;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instruction;
  logic [1:0]      alu_op;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  int checks = 0;
  int errors = 0;

  alu_iter_exec #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instruction (instruction),
    .alu_op      (alu_op),
    .op_a        (op_a),
    .op_b        (op_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .illegal     (illegal)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: operation kind from the R-type encoding table
  function automatic int rtype_kind(input logic [6:0] f7, input logic [2:0] f3);
    case ({f7, f3})
      {7'h00, 3'd0}: return K_ADD;
      {7'h20, 3'd0}: return K_SUB;
      {7'h00, 3'd1}: return K_SLL;
      {7'h00, 3'd2}: return K_SLT;
      {7'h00, 3'd3}: return K_SLTU;
      {7'h00, 3'd4}: return K_XOR;
      {7'h00, 3'd5}: return K_SRL;
      {7'h20, 3'd5}: return K_SRA;
      {7'h00, 3'd6}: return K_OR;
      {7'h00, 3'd7}: return K_AND;
      {7'h01, 3'd0}: return K_MUL;
`ifdef ALU_ITER_DIV_EN
      {7'h01, 3'd5}: return K_DIVU;
      {7'h01, 3'd7}: return K_REMU;
`endif
      default:       return K_ILL;
    endcase
  endfunction

  function automatic int kind_of(input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3);
    logic [6:0] key7;
    if (aop == 2'b00) return K_ADD;
    if (aop == 2'b01) return K_SUB;
    if (aop == 2'b10) return rtype_kind(f7, f3);
    // I-type: funct7 is normalised, except that a shift-left needs an all-zero funct7
    if (f3 == 3'd1)                       key7 = f7;
    else if (f3 == 3'd5 && f7 == 7'h20)   key7 = 7'h20;
    else                                  key7 = 7'h00;
    return rtype_kind(key7, f3);
  endfunction

  function automatic logic [31:0] eval(input int k, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    case (k)
      K_ADD:  return a + b;
      K_SUB:  return a - b;
      K_SLL:  return a << b[4:0];
      K_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      K_SLTU: return (a < b) ? 32'd1 : 32'd0;
      K_XOR:  return a ^ b;
      K_SRL:  return a >> b[4:0];
      K_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      K_OR:   return a | b;
      K_AND:  return a & b;
      K_MUL:  begin prod = 64'(a) * 64'(b); return prod[31:0]; end
      K_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      K_REMU: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Driver: issue one op, follow it to the output handshake, check everything on the way
  task automatic run_op(input string tag, input logic [1:0] aop, input logic [6:0] f7,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    int          k;
    int          exp_lat;
    int          lat;
    logic [31:0] exp_r;
    logic        exp_ill;
    logic        busy_ok;
    logic        hold_ok;
    logic [31:0] exp_q[$];

    k       = kind_of(aop, f7, f3);
    exp_ill = (k == K_ILL);
    exp_r   = exp_ill ? 32'd0 : eval(k, a, b);
    exp_lat = (k == K_MUL || k == K_DIVU || k == K_REMU) ? XLEN + 1 : 1;
    exp_q.push_back(exp_r);

    @(negedge clk);
    check({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid    = 1'b1;
    alu_op      = aop;
    instruction = {f7, 10'($urandom), f3, 12'($urandom)};
    op_a        = a;
    op_b        = b;
    out_ready   = 1'b0;
    @(posedge clk);
    #1;
    lat     = 1;
    busy_ok = 1'b1;
    while (out_valid !== 1'b1 && lat < 100) begin
      // Scramble inputs while busy; none of it may be taken
      in_valid    = 1'($urandom);
      op_a        = $urandom;
      op_b        = $urandom;
      alu_op      = 2'($urandom);
      instruction = $urandom;
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy_in_ready_low"}, 32'(busy_ok), 32'd1);
    check({tag, " result"}, result, exp_q[0]);
    check({tag, " zero"}, 32'(zero), 32'(exp_q[0] == 32'd0));
    check({tag, " illegal"}, 32'(illegal), 32'(exp_ill));
    hold_ok = (in_ready === 1'b0);
    repeat (hold) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || result !== exp_q[0] || zero !== (exp_q[0] == 32'd0) ||
          illegal !== exp_ill || in_ready !== 1'b0) hold_ok = 1'b0;
    end
    check({tag, " hold_stable"}, 32'(hold_ok), 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " out_valid_after_hs"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready_after_hs"}, 32'(in_ready), 32'd1);
    void'(exp_q.pop_front());
  endtask

  logic [31:0] special [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd7};
  logic [6:0]  f7_pick [4] = '{7'h00, 7'h20, 7'h01, 7'h7F};

  initial begin
    logic        no_spurious;
    logic [6:0]  rf7;
    logic [31:0] ra;
    logic [31:0] rb;
    int          hold;

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    alu_op      = 2'b00;
    instruction = 32'd0;
    op_a        = '0;
    op_b        = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", result, 32'd0);
    check("reset zero", 32'(zero), 32'd0);
    check("reset illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed steps
    run_op("add5_7",   2'b10, 7'h00, 3'd0, 32'd5, 32'd7, 0);
    run_op("sra",      2'b10, 7'h20, 3'd5, 32'h8000_0000, 32'd4, 0);
    run_op("srl",      2'b10, 7'h00, 3'd5, 32'h8000_0000, 32'd4, 0);
    run_op("mul_m1x3", 2'b10, 7'h01, 3'd0, 32'hFFFF_FFFF, 32'd3, 0);
    run_op("and_hold", 2'b10, 7'h00, 3'd7, 32'h0000_00F0, 32'h0000_000F, 5);
    run_op("illegal",  2'b10, 7'h7F, 3'd0, 32'd9, 32'd3, 1);
    run_op("sub_wrap", 2'b01, 7'h55, 3'd6, 32'd3, 32'd5, 0);
    run_op("add_wrap", 2'b00, 7'h00, 3'd0, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("slt_neg",  2'b10, 7'h00, 3'd2, 32'h8000_0000, 32'd1, 0);
    run_op("sltu_big", 2'b10, 7'h00, 3'd3, 32'h8000_0000, 32'd1, 0);
    run_op("sll_31",   2'b10, 7'h00, 3'd1, 32'd1, 32'hFFFF_FFFF, 0);
    run_op("i_sra",    2'b11, 7'h20, 3'd5, 32'hF000_0000, 32'd8, 0);
    run_op("i_srl",    2'b11, 7'h13, 3'd5, 32'hF000_0000, 32'd8, 0);
    run_op("i_sll_bad", 2'b11, 7'h20, 3'd1, 32'd1, 32'd2, 0);
    run_op("i_add_f7", 2'b11, 7'h20, 3'd0, 32'd10, 32'd20, 0);
    run_op("mul_max",  2'b10, 7'h01, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    run_op("mul_zero", 2'b10, 7'h01, 3'd0, 32'h1234_5678, 32'd0, 0);
    run_op("divu",     2'b10, 7'h01, 3'd5, 32'd100, 32'd7, 0);
    run_op("remu",     2'b10, 7'h01, 3'd7, 32'd100, 32'd7, 0);
    run_op("divu_by0", 2'b10, 7'h01, 3'd5, 32'd1234, 32'd0, 0);
    run_op("remu_by0", 2'b10, 7'h01, 3'd7, 32'd1234, 32'd0, 0);

    // Randomized steps
    for (int i = 0; i < 40; i++) begin
      rf7  = ($urandom_range(0, 4) == 0) ? 7'($urandom) : f7_pick[$urandom_range(0, 3)];
      ra   = ($urandom_range(0, 2) == 0) ? special[$urandom_range(0, 5)] : $urandom;
      rb   = ($urandom_range(0, 2) == 0) ? special[$urandom_range(0, 5)] : $urandom;
      hold = int'($urandom_range(0, 3));
      run_op($sformatf("rand%0d", i), 2'($urandom), rf7, 3'($urandom), ra, rb, hold);
    end

    // Reset in the middle of a multiply
    @(negedge clk);
    in_valid    = 1'b1;
    alu_op      = 2'b10;
    instruction = {7'h01, 10'd0, 3'd0, 12'd0};
    op_a        = 32'd6;
    op_b        = 32'd7;
    out_ready   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mul out_valid", 32'(out_valid), 32'd0);
    check("rst_mul result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_mul in_ready", 32'(in_ready), 32'd1);
    no_spurious = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) no_spurious = 1'b0;
    end
    check("rst_mul no_spurious", 32'(no_spurious), 32'd1);
    out_ready = 1'b0;
    run_op("after_rst", 2'b10, 7'h00, 3'd4, 32'hA5A5_A5A5, 32'hFFFF_0000, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_iter_exec.md
Name: alu_iter_exec

Overview:
- Parametrised successor to the combinational ALU-control decode.
- Decodes ALUOp plus funct7/funct3 from the instruction word, then executes the operation.
- Single-cycle ops complete with 1-cycle latency. RV32M MUL runs on an iterative shift-add datapath.
- Sits between the register-read stage and writeback. Upstream and downstream use valid/ready handshakes, so the pipeline stalls on multi-cycle ops.

Parameters:
- XLEN, 32, operand/result width (≥8, power of 2).
- CNT_W, $clog2(XLEN+1), iteration counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands/instruction valid.
- in_ready  out  1  unit can accept; transfer when in_valid && in_ready.
- instruction  in  32  instruction word; only [31:25] (funct7) and [14:12] (funct3) are used.
- alu_op  in  2  00 add, 01 sub, 10 R-type decode, 11 I-type decode.
- op_a  in  XLEN  operand A.
- op_b  in  XLEN  operand B (or immediate).
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  downstream accepts.
- result  out  XLEN  operation result.
- zero  out  1  result == 0.
- illegal  out  1  undecodable op; result forced to 0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; out_valid=0; result=0; zero=0; illegal=0; counter and accumulators 0.
  - in_ready deasserts immediately (combinational from state).
- States: IDLE, MUL, OUT.
- in_ready = (state==IDLE).
- IDLE, on accept: decode and compute.
  - Single-cycle op: register result, illegal, zero; go to OUT. out_valid rises the next cycle (latency 1).
  - MUL: latch op_a into multiplicand, op_b into multiplier, clear acc, counter=0; go to MUL.
- MUL: each cycle:
  - if multiplier[0], acc += multiplicand;
  - multiplicand <<= 1; multiplier >>= 1; counter++.
  - After XLEN iterations (counter==XLEN-1 on the last add), go to OUT.
  - Result = low XLEN bits of the product (signedness irrelevant).
  - Latency from accept to out_valid = XLEN+1 cycles.
- OUT: out_valid=1; result/zero/illegal stable. On out_ready, go to IDLE next cycle; out_valid falls.
  - A new accept can occur one cycle after the out handshake; no back-to-back overlap.
- Decode:
  - alu_op=00: add. alu_op=01: sub. funct fields ignored.
  - alu_op=10, {funct7,funct3}:
    - 0000000/000 add; 0100000/000 sub; 0000000/001 sll; 0000000/010 slt (signed);
    - 0000000/011 sltu; 0000000/100 xor; 0000000/101 srl; 0100000/101 sra;
    - 0000000/110 or; 0000000/111 and; 0000001/000 mul.
    - Anything else is illegal.
  - alu_op=11: funct3 selects the same op as R-type; funct7 is ignored except:
    - funct3=101 with funct7=0100000 selects sra; any other funct7 selects srl.
    - funct3=001 requires funct7=0000000, else illegal.
- Arithmetic:
  - Shift amount = op_b[$clog2(XLEN)-1:0].
  - add/sub wrap modulo 2^XLEN.
  - slt/sltu return {XLEN-1 zeros, bit}.
- Illegal: completes as a single-cycle op with result=0, zero=1, illegal=1.
- Input changes while not accepting are ignored.
- Reset mid-MUL aborts the operation; no result is produced.

Optional Feature:
- Macro ALU_ITER_DIV_EN.
- Defined: adds DIV_ST state and restoring unsigned divide.
  - {funct7,funct3} 0000001/101 = divu; 0000001/111 = remu.
  - XLEN iterations; latency XLEN+1.
  - Divide by zero: divu result all ones; remu result = op_a.
  - Not illegal.
- Undefined: those encodings are flagged illegal (result 0); no divider logic is synthesised.

Test Plan:
- Reset, then alu_op=10, funct 0000000/000, a=5, b=7, out_ready=1 -> out_valid 1 cycle after accept, result=12, zero=0, illegal=0.
- alu_op=10, 0100000/101 (sra), a=0x80000000, b=4 -> result=0xF8000000. Then srl with the same operands -> 0x08000000.
- mul, a=0xFFFFFFFF, b=3 -> result=0xFFFFFFFD exactly 33 cycles after accept; in_ready=0 throughout.
- Single-cycle and, a=0xF0, b=0x0F, with out_ready held low 5 cycles -> result=0, zero=1, out_valid and result stable for 5 cycles; in_ready=0 until one cycle after the handshake.
- alu_op=10, funct 1111111/000 -> illegal=1, result=0. Separately, assert rst_n low at cycle 10 of a mul -> out_valid=0, returns to IDLE, no spurious result.
- With ALU_ITER_DIV_EN: divu 100/7 -> 14; remu 100/7 -> 2; divu x/0 -> 0xFFFFFFFF. Without the macro, divu -> illegal=1.
